// File: rtl/recv_pkg.sv
// recv_pkg: shared router packet layout, matcher result codes and pacer state encoding.
package recv_pkg;
  localparam int PKT_WIDTH = 128;
  localparam int TYPE_MSB  = 127;
  localparam int TYPE_LSB  = 123;
  localparam int MATCH_MSB = 103;
  localparam int MATCH_LSB = 88;
  localparam int DATA_MSB  = 87;
  localparam int DATA_LSB  = 56;
  localparam int SEQ_MSB   = 10;
  localparam logic [4:0]  TYPE_EAGER  = 5'b10000;
  localparam logic [31:0] RES_MATCH   = 32'h52052020;
  localparam logic [31:0] RES_NOMATCH = 32'hdeaddead;
  localparam logic [31:0] RES_ERROR   = 32'haaaadead;
  typedef enum logic {S_IDLE, S_GAP} pace_state_e;
  // Router packets without the top type bit are malformed and never reach the matcher.
  function automatic logic is_wellformed(input logic [PKT_WIDTH-1:0] p);
    return p[TYPE_MSB];
  endfunction
endpackage

// File: rtl/recv_pkt_fifo.sv
// recv_pkt_fifo: register-array packet FIFO; full/empty come from the level, pointers wrap naturally.
module recv_pkt_fifo #(
  parameter int W   = 128,
  parameter int DL2 = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_push,
  input  logic [W-1:0]   i_wdata,
  input  logic           i_pop,
  output logic [W-1:0]   o_rdata,
  output logic [DL2:0]   o_level,
  output logic           o_full,
  output logic           o_empty
);
  localparam int DEPTH = 1 << DL2;
  logic [W-1:0]   r_mem [DEPTH];
  logic [DL2-1:0] r_wr;
  logic [DL2-1:0] r_rd;
  logic [DL2:0]   r_level;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_level <= r_level + (DL2+1)'(i_push) - (DL2+1)'(i_pop);
    end
  assign o_rdata = r_mem[r_rd];
  assign o_level = r_level;
  assign o_full  = r_level == (DL2+1)'(DEPTH);
  assign o_empty = r_level == '0;
endmodule

// File: rtl/recv_ingress_pacer.sv
// recv_ingress_pacer: filters and buffers router packets, re-issuing them to the matcher
// as single-cycle pulses at least MIN_SPACING cycles apart, with saturating statistics.
module recv_ingress_pacer #(
  parameter int PKT_WIDTH   = recv_pkg::PKT_WIDTH,
  parameter int DEPTH_LOG2  = 4,
  parameter int MIN_SPACING = 4,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                  nios_clk,
  input  logic                  reset_n,
  input  logic [PKT_WIDTH-1:0]  packet_in,
  input  logic                  packet_in_valid,
  input  logic                  hold,
  input  logic                  clear_stats,
  output logic [PKT_WIDTH-1:0]  packet_out,
  output logic                  packet_out_valid,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic [STAT_WIDTH-1:0] drop_count,
  output logic [STAT_WIDTH-1:0] malformed_count,
  output logic [STAT_WIDTH-1:0] issued_count
);
  import recv_pkg::*;
  localparam int GW = $clog2(MIN_SPACING);
  pace_state_e r_state, w_next;
  logic [GW-1:0]         r_gap;
  logic [PKT_WIDTH-1:0]  r_out;
  logic                  r_valid;
  logic                  r_ovf;
  logic [STAT_WIDTH-1:0] r_drop, r_malf, r_iss;
  logic [PKT_WIDTH-1:0]  w_head;
  logic                  w_full, w_empty, w_pop, w_push, w_drop, w_malf, w_good;
  assign w_good = packet_in_valid & is_wellformed(packet_in);
  assign w_malf = packet_in_valid & ~is_wellformed(packet_in);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = w_good & (~w_full | w_pop);
  assign w_drop = w_good & w_full & ~w_pop;
  recv_pkt_fifo #(.W(PKT_WIDTH), .DL2(DEPTH_LOG2)) u_fifo (
    .clk     (nios_clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_wdata (packet_in),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge nios_clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == S_IDLE) ? (w_pop ? S_GAP : S_IDLE)
                                 : ((r_gap == GW'(1)) ? S_IDLE : S_GAP);
  always_comb
    w_pop = (r_state == S_IDLE) & ~w_empty & ~hold;
  always_ff @(posedge nios_clk or negedge reset_n)
    if (!reset_n) begin
      r_gap   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_out <= w_head;
        r_gap <= GW'(MIN_SPACING - 1);
      end else if (r_state == S_GAP) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  // Clear takes priority over any event landing in the same cycle.
  always_ff @(posedge nios_clk or negedge reset_n)
    if (!reset_n) begin
      r_drop <= '0;
      r_malf <= '0;
      r_iss  <= '0;
      r_ovf  <= 1'b0;
    end else if (clear_stats) begin
      r_drop <= '0;
      r_malf <= '0;
      r_iss  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_drop && !(&r_drop)) r_drop <= r_drop + 1'b1;
      if (w_malf && !(&r_malf)) r_malf <= r_malf + 1'b1;
      if (w_pop && !(&r_iss)) r_iss <= r_iss + 1'b1;
      if (w_drop) r_ovf <= 1'b1;
    end
  assign packet_out       = r_out;
  assign packet_out_valid = r_valid;
  assign overflow         = r_ovf;
  assign drop_count       = r_drop;
  assign malformed_count  = r_malf;
  assign issued_count     = r_iss;
endmodule

// File: tb/tb_recv_ingress_pacer.sv
// tb_recv_ingress_pacer: randomized and directed stimulus checked every cycle against a
// queue/timestamp model of the pacer, plus literal expectations for the key scenarios.
module tb_recv_ingress_pacer;
  localparam int W = 128, DL2 = 4, MS = 4, SW = 16, DEPTH = 16;
  logic          nios_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  packet_in = '0;
  logic          packet_in_valid = 1'b0;
  logic          hold = 1'b0;
  logic          clear_stats = 1'b0;
  logic [W-1:0]  packet_out;
  logic          packet_out_valid;
  logic [DL2:0]  fifo_level;
  logic          overflow;
  logic [SW-1:0] drop_count, malformed_count, issued_count;
  recv_ingress_pacer #(.PKT_WIDTH(W), .DEPTH_LOG2(DL2), .MIN_SPACING(MS), .STAT_WIDTH(SW)) dut (
    .nios_clk        (nios_clk),
    .reset_n         (reset_n),
    .packet_in       (packet_in),
    .packet_in_valid (packet_in_valid),
    .hold            (hold),
    .clear_stats     (clear_stats),
    .packet_out      (packet_out),
    .packet_out_valid(packet_out_valid),
    .fifo_level      (fifo_level),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .malformed_count (malformed_count),
    .issued_count    (issued_count)
  );
  always #5 nios_clk = ~nios_clk;
  int compared = 0, mismatched = 0;
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int sat(input int v);
    return (v > (1 << SW) - 1) ? (1 << SW) - 1 : v;
  endfunction
  // Reference model: a queue of accepted packets and the cycle of the last issue.
  logic [W-1:0] mq[$];
  int m_cyc = 0, m_last = -100, m_drop = 0, m_malf = 0, m_iss = 0;
  logic [W-1:0] m_out = '0;
  bit m_valid = 0, m_ovf = 0, m_now = 0, m_full = 0;
  always @(posedge nios_clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_cyc = 0; m_last = -100; m_out = '0; m_valid = 0; m_ovf = 0;
      m_drop = 0; m_malf = 0; m_iss = 0;
    end else begin
      m_cyc++;
      m_now = mq.size() > 0 && !hold && (m_cyc - m_last >= MS);
      m_full = mq.size() == DEPTH;
      m_valid = m_now;
      if (m_now) begin
        m_out = mq.pop_front();
        m_last = m_cyc;
        m_iss = sat(m_iss + 1);
      end
      if (packet_in_valid) begin
        if (!packet_in[127]) m_malf = sat(m_malf + 1);
        else if (!m_full || m_now) mq.push_back(packet_in);
        else begin
          m_drop = sat(m_drop + 1);
          m_ovf = 1;
        end
      end
      if (clear_stats) begin
        m_drop = 0; m_malf = 0; m_iss = 0; m_ovf = 0;
      end
    end
  end
  int cyc = 0;
  int p_cyc[$];
  logic [W-1:0] p_dat[$];
  always @(posedge nios_clk) cyc++;
  always @(negedge nios_clk) if (reset_n) begin
    check("packet_out", packet_out, m_out);
    check("packet_out_valid", W'(packet_out_valid), W'(m_valid));
    check("fifo_level", W'(fifo_level), W'(mq.size()));
    check("overflow", W'(overflow), W'(m_ovf));
    check("drop_count", W'(drop_count), W'(m_drop));
    check("malformed_count", W'(malformed_count), W'(m_malf));
    check("issued_count", W'(issued_count), W'(m_iss));
    if (packet_out_valid) begin
      p_cyc.push_back(cyc);
      p_dat.push_back(packet_out);
    end
  end
  task automatic drive(input bit v, input logic [W-1:0] p, input bit h, input bit c);
    @(negedge nios_clk);
    packet_in_valid = v; packet_in = p; hold = h; clear_stats = c;
  endtask
  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) drive(0, '0, h, 0);
  endtask
  function automatic logic [W-1:0] mk(input int i);
    logic [W-1:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[127:123] = 5'b10000;
    r[87:56] = 32'hCAFE0000 + i;
    return r;
  endfunction
  task automatic check_pulses(input string name, input int n, input logic [W-1:0] exp[$]);
    check({name, "_count"}, W'(p_cyc.size()), W'(n));
    for (int i = 0; i < n && i < p_dat.size(); i++) check({name, "_data"}, p_dat[i], exp[i]);
  endtask
  logic [W-1:0] sent[$];
  logic [W-1:0] pk;
  int t;
  initial begin
    repeat (3) @(negedge nios_clk);
    check("rst_packet_out", packet_out, '0);
    check("rst_valid", W'(packet_out_valid), '0);
    check("rst_level", W'(fifo_level), '0);
    check("rst_counts", W'({overflow, drop_count, malformed_count, issued_count}), '0);
    reset_n = 1'b1;
    idle(6, 0);
    // single eager packet
    p_cyc.delete(); p_dat.delete(); sent.delete();
    pk = mk(1);
    pk[87:56] = 32'hCAFE0001;
    sent.push_back(pk);
    drive(1, pk, 0, 0);
    drive(0, '0, 0, 0);
    t = cyc;
    idle(5, 0);
    check_pulses("single", 1, sent);
    if (p_cyc.size() > 0) check("single_latency", W'(p_cyc[0] - t), W'(1));
    check("single_issued", W'(issued_count), W'(1));
    check("single_level", W'(fifo_level), '0);
    // five back-to-back strobes
    p_cyc.delete(); p_dat.delete(); sent.delete();
    for (int i = 0; i < 5; i++) begin
      sent.push_back(mk(10 + i));
      drive(1, sent[i], 0, 0);
    end
    drive(0, '0, 0, 0);
    t = cyc - 4;
    idle(25, 0);
    check_pulses("burst5", 5, sent);
    for (int i = 0; i < 5 && i < p_cyc.size(); i++) check("burst5_time", W'(p_cyc[i] - t), W'(1 + 4 * i));
    check("burst5_drop", W'(drop_count), '0);
    // overflow under hold
    sent.delete();
    for (int i = 0; i < 20; i++) begin
      sent.push_back(mk(100 + i));
      drive(1, sent[i], 1, 0);
    end
    drive(0, '0, 1, 0);
    check("hold_drop", W'(drop_count), W'(4));
    check("hold_overflow", W'(overflow), W'(1));
    check("hold_level", W'(fifo_level), W'(16));
    p_cyc.delete(); p_dat.delete();
    idle(70, 0);
    check_pulses("hold_drain", 16, sent);
    drive(0, '0, 0, 1);
    drive(0, '0, 0, 0);
    check("clear_counts", W'({overflow, drop_count, malformed_count, issued_count}), '0);
    // malformed packet between two good ones
    p_cyc.delete(); p_dat.delete(); sent.delete();
    sent.push_back(mk(200));
    sent.push_back(mk(202));
    pk = mk(201);
    pk[127] = 1'b0;
    drive(1, sent[0], 0, 0);
    drive(1, pk, 0, 0);
    drive(1, sent[1], 0, 0);
    idle(12, 0);
    check("malformed_count_lit", W'(malformed_count), W'(1));
    check_pulses("malformed", 2, sent);
    // push on the issue edge of a full FIFO
    for (int i = 0; i < 16; i++) drive(1, mk(300 + i), 1, 0);
    drive(1, mk(316), 0, 0);
    drive(0, '0, 0, 0);
    check("fullpush_level", W'(fifo_level), W'(16));
    check("fullpush_drop", W'(drop_count), '0);
    idle(75, 0);
    // async reset mid-gap with three packets queued
    for (int i = 0; i < 4; i++) drive(1, mk(400 + i), 1, 0);
    drive(0, '0, 0, 0);
    drive(0, '0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_packet_out", packet_out, '0);
    check("midrst_valid", W'(packet_out_valid), '0);
    check("midrst_level", W'(fifo_level), '0);
    check("midrst_issued", W'(issued_count), '0);
    @(negedge nios_clk);
    reset_n = 1'b1;
    p_cyc.delete(); p_dat.delete();
    idle(12, 0);
    check("postrst_pulses", W'(p_cyc.size()), '0);
    drive(1, mk(500), 0, 0);
    idle(3, 0);
    check("postrst_new", W'(p_cyc.size()), W'(1));
    // randomized traffic with alternating hold pressure
    for (int i = 0; i < 3000; i++) begin
      pk = {$urandom, $urandom, $urandom, $urandom};
      pk[127] = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 99) < 45, pk,
            $urandom_range(0, 99) < (((i / 300) % 2) ? 80 : 15),
            $urandom_range(0, 249) == 0);
    end
    idle(80, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/recv_ingress_pacer.md
Name: recv_ingress_pacer

Overview:
- Ingress stage between the network router and the receive-side message matcher.
- Captures each 128-bit router packet, which arrives as a fire-and-forget pulse with no backpressure, into a FIFO.
- Discards malformed packets and re-issues packets to the matcher as single-cycle valid pulses, spaced so the matcher's WAIT→LOOKING→FIN walk never misses or overlaps a packet.
- Exposes drop/occupancy statistics to the NIOS II.

Parameters:
- PKT_WIDTH, 128, packet width (router format: [127:123] type, [103:88] match key, [87:56] payload, [10:0] seq/size).
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16).
- MIN_SPACING, 4, minimum clock cycles between consecutive packet_out_valid pulses (≥2).
- STAT_WIDTH, 16, width of saturating statistics counters.

Ports:
- nios_clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- packet_in  in  PKT_WIDTH  packet from router.
- packet_in_valid  in  1  one-cycle strobe; packet_in is valid this cycle.
- hold  in  1  when 1, no new issue starts; a queued packet stays queued.
- clear_stats  in  1  synchronous pulse; zeroes counters and overflow flag.
- packet_out  out  PKT_WIDTH  packet to matcher; held stable between issues.
- packet_out_valid  out  1  one-cycle issue strobe.
- fifo_level  out  DEPTH_LOG2+1  current occupancy.
- overflow  out  1  sticky; set on any overflow drop.
- drop_count  out  STAT_WIDTH  overflow drops, saturating.
- malformed_count  out  STAT_WIDTH  packets discarded for type[127]==0, saturating.
- issued_count  out  STAT_WIDTH  packets issued, saturating.

Behaviour:
- Reset (reset_n low, async): FIFO empty, pointers 0, packet_out=0, packet_out_valid=0, all counters 0, overflow=0, FSM=IDLE. Reset mid-issue discards all queued packets. No output pulse follows reset release until a new packet is accepted.
- Acceptance, each cycle with packet_in_valid=1:
  - packet_in[127]==0: discard; malformed_count++.
  - Else if the FIFO is not full, or a pop occurs the same cycle: push.
  - Else: drop; drop_count++; overflow<=1.
  - Counters saturate at all-ones.
- Simultaneous push and pop when full: both occur; level unchanged; no drop.
- clear_stats concurrent with a drop/malformed event: clear wins; counter=0, overflow=0.
- Issue FSM:
  - IDLE: if fifo non-empty and hold==0, pop head, register it into packet_out, and assert packet_out_valid for exactly one cycle. Load the gap counter with MIN_SPACING-1 and go to GAP.
  - GAP: decrement the gap counter; on reaching 0 go to IDLE. hold is ignored here; the counter still runs.
  - Only one issue per visit to IDLE. Pulses are therefore ≥MIN_SPACING cycles apart; with hold=0 and a backlog, spacing is exactly MIN_SPACING.
- Latency: a packet accepted at edge E into an empty FIFO with FSM IDLE and hold=0 gives packet_out_valid=1 after edge E+1 (1-cycle latency). First-word fall-through is not required.
- packet_out changes only at an issue edge, and holds the last issued packet otherwise; the matcher re-samples it for ≥2 cycles.
- fifo_level is registered and reflects pushes/pops of the previous edge. Range 0..2**DEPTH_LOG2.
- Pointers are DEPTH_LOG2 bits and wrap naturally. Full/empty are derived from level, not from pointer compare.
- issued_count increments on each packet_out_valid.
- Ordering is strict FIFO; no reordering by type.

Decomposition:
- Shared package recv_pkg:
  - PKT_WIDTH.
  - Header field ranges: TYPE_MSB=127, TYPE_LSB=123, MATCH_MSB=103, MATCH_LSB=88, DATA_MSB=87, DATA_LSB=56, SEQ_MSB=10.
  - Type codes: TYPE_EAGER=5'b10000.
  - Result codes shared with the matcher: 32'h52052020, 32'hdeaddead, 32'haaaadead.
- One sub-module: recv_pkt_fifo, a synchronous register-array FIFO with push/pop/level/full/empty and async active-low reset.
- Pacer FSM, filter and counters live in the top.

Test Plan:
- Single eager packet (127:123=10000, data 32'hCAFE0001) into idle block: packet_out_valid high exactly one cycle, one cycle after acceptance; packet_out equal to the input; issued_count=1; fifo_level returns to 0.
- 5 back-to-back strobes on consecutive cycles, MIN_SPACING=4: pulses at cycles t+1, t+5, t+9, t+13, t+17; order preserved; drop_count=0.
- 20 consecutive strobes with hold=1: 16 accepted, 4 dropped, drop_count=4, overflow=1, fifo_level=16. Release hold: 16 issues in order. Then clear_stats: counters 0, overflow 0.
- Packet with bit127=0 interleaved between two valid packets: malformed_count=1; only the 2 valid packets are issued.
- Full FIFO with a push on the same cycle as an issue: level stays 16, no drop recorded.
- Assert reset_n low asynchronously mid-GAP with 3 queued packets: outputs immediately 0. After release, no pulse until a new packet arrives.
